// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter: registered one-hot grant held until NEXT or withdrawal,
// zero-bubble handover. Optional tenure limit enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 16,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [N-1:0]  REQ,
    input  logic          NEXT,
    output logic [N-1:0]  GNT,
    output logic [IW-1:0] GNT_ID,
    output logic          VALID
);

    if (N < 2 || N > 32 || HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_param_check
        $error("rr_arbiter_n: parameter out of range");
    end

    // First set bit of v scanning upward from ptr with wrap; returns {found, index}.
    function automatic logic [IW:0] winner(input logic [IW-1:0] ptr, input logic [N-1:0] v);
        logic          found;
        logic [IW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && v[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        return {found, idx};
    endfunction

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_inc;
    logic [IW-1:0] scan_ptr;
    logic [N-1:0]  others;
    logic [N-1:0]  scan_vec;
    logic [N-1:0]  win_oh;
    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic          rel;
    logic          load;
    logic          force_rel;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int            CW      = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(HOLD_MAX - 1);
    logic [CW-1:0] cnt;

    // Tenure restarts on every new grant and saturates at the limit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            cnt <= '0;
        else if (load && win_vld)
            cnt <= '0;
        else if (VALID && cnt != CNT_LIM)
            cnt <= cnt + 1'b1;
    end

    assign force_rel = (cnt == CNT_LIM) && (|others);
`else
    assign force_rel = 1'b0;
`endif

    // While granted, the scan starts after the holder with the holder masked out,
    // so the handover edge never re-selects it.
    always_comb begin
        ptr_inc  = (GNT_ID == IW'(N - 1)) ? '0 : GNT_ID + 1'b1;
        others   = REQ & ~GNT;
        rel      = VALID && (NEXT || !REQ[GNT_ID] || force_rel);
        scan_ptr = VALID ? ptr_inc : ptr;
        scan_vec = VALID ? others : REQ;
        {win_vld, win_idx} = winner(scan_ptr, scan_vec);
        win_oh   = N'(1) << win_idx;
        load     = VALID ? rel : win_vld;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr    <= '0;
            GNT    <= '0;
            GNT_ID <= '0;
            VALID  <= 1'b0;
        end else if (load) begin
            if (VALID) ptr <= ptr_inc;
            if (win_vld) begin
                GNT    <= win_oh;
                GNT_ID <= win_idx;
                VALID  <= 1'b1;
            end else begin
                GNT    <= '0;
                VALID  <= 1'b0;
            end
        end
    end

    a_onehot: assert property (@(posedge CLK) disable iff (!RESET) $onehot0(GNT));
    a_valid:  assert property (@(posedge CLK) disable iff (!RESET) VALID == (|GNT));
    a_id:     assert property (@(posedge CLK) disable iff (!RESET) VALID |-> GNT[GNT_ID]);

endmodule
